// File: rtl/frame_pkg.sv
// Shared types and constants for the receive-path frame sequencer.
package frame_pkg;

  typedef enum logic [1:0] {
    PRE_B   = 2'd0,
    PRE_M   = 2'd1,
    PRE_W   = 2'd2,
    PRE_INV = 2'd3
  } preamble_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } seq_state_t;

  localparam int FRAMES_PER_BLOCK_DEF = 192;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Preamble the line should deliver for the subframe at (frame, channel).
  function automatic preamble_t expected_pre(input logic [7:0] fc, input logic ch);
    if (ch == CH_B) begin
      return PRE_W;
    end else if (fc == 8'd0) begin
      return PRE_B;
    end
    return PRE_M;
  endfunction

endpackage

// File: rtl/frame_sequencer_watchdog.sv
// seq_watchdog: counts enabled cycles since the last clear and pulses expire
// for one cycle when TIMEOUT-1 is reached (TIMEOUT must be at least 2).
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = en_i && !clr_i && (cnt_q == LAST);
    cnt_d    = cnt_q + CW'(1);
    if (clr_i || !en_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Preamble sync/sequencing controller for the subframe dismantler.
// Optional kill statistics counter is built when SEQ_STATS_EN is defined.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int FRAMES_PER_BLOCK = FRAMES_PER_BLOCK_DEF,
  parameter int LOCK_FRAMES      = 4,
  parameter int MISS_LIMIT       = 3,
  parameter int TIMEOUT          = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_valid,
  input  logic [1:0]  pre_type,
  input  logic        done,
  output logic [7:0]  frame_counter,
  output logic        in_channel,
  output logic        out_channel,
  output logic        kill,
  output logic        locked,
  output logic        block_start,
  output logic [15:0] sync_err_count
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int EW = $clog2(MISS_LIMIT + 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);
  localparam logic [EW-1:0] ERR_LIMIT = EW'(MISS_LIMIT);
  localparam logic [7:0]    FC_LAST   = 8'(FRAMES_PER_BLOCK - 1);

  seq_state_t    state_q, state_d;
  logic [7:0]    fc_q, fc_d;
  logic          in_ch_q, in_ch_d;
  logic          out_ch_q, out_ch_d;
  logic          busy_q, busy_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [EW-1:0] err_q, err_d, err_inc;
  logic          kill_q, kill_d;
  logic          bs_q, bs_d;
  logic          locked_q;
  logic          wd_expire;
  preamble_t     pre_type_e;
  preamble_t     exp_pre;
  logic          pre_match;

  assign pre_type_e = preamble_t'(pre_type);
  assign good_inc   = good_q + GW'(1);
  assign err_inc    = err_q + EW'(1);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (pre_valid),
    .en_i     (state_q != SEARCH),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    in_ch_d  = in_ch_q;
    out_ch_d = out_ch_q;
    busy_d   = busy_q;
    good_d   = good_q;
    err_d    = err_q;
    kill_d   = 1'b0;
    bs_d     = 1'b0;

    // A completed subframe advances position before the same-cycle preamble is judged.
    if ((state_q != SEARCH) && done && busy_q) begin
      out_ch_d = in_ch_q;
      in_ch_d  = ~in_ch_q;
      busy_d   = 1'b0;
      if (in_ch_q == CH_B) begin
        fc_d = (fc_q == FC_LAST) ? 8'd0 : fc_q + 8'd1;
      end
    end

    exp_pre   = expected_pre(fc_d, in_ch_d);
    pre_match = (pre_type_e == exp_pre) && (pre_type_e != PRE_INV) && !busy_d;

    if (pre_valid) begin
      case (state_q)
        SEARCH: begin
          if (pre_type_e == PRE_B) begin
            fc_d    = 8'd0;
            in_ch_d = CH_A;
            busy_d  = 1'b1;
            good_d  = GW'(1);
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (pre_match) begin
            busy_d = 1'b1;
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              err_d   = '0;
              state_d = LOCKED;
            end
          end else begin
            kill_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (pre_match) begin
            err_d  = '0;
            busy_d = 1'b1;
            bs_d   = (pre_type_e == PRE_B);
          end else begin
            kill_d = 1'b1;
            err_d  = err_inc;
            if (err_inc == ERR_LIMIT) begin
              err_d   = '0;
              busy_d  = 1'b0;
              state_d = SEARCH;
            end else begin
              // Realign to whatever the line actually sent.
              case (pre_type_e)
                PRE_B: begin
                  fc_d    = 8'd0;
                  in_ch_d = CH_A;
                  busy_d  = 1'b1;
                end
                PRE_M: begin
                  in_ch_d = CH_A;
                  busy_d  = 1'b1;
                end
                PRE_W: begin
                  in_ch_d = CH_B;
                  busy_d  = 1'b1;
                end
                default: busy_d = 1'b0;
              endcase
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (wd_expire) begin
      kill_d  = 1'b1;
      busy_d  = 1'b0;
      err_d   = '0;
      state_d = SEARCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      fc_q     <= 8'd0;
      in_ch_q  <= 1'b0;
      out_ch_q <= 1'b0;
      busy_q   <= 1'b0;
      good_q   <= '0;
      err_q    <= '0;
      kill_q   <= 1'b0;
      bs_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      in_ch_q  <= in_ch_d;
      out_ch_q <= out_ch_d;
      busy_q   <= busy_d;
      good_q   <= good_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
      bs_q     <= bs_d;
      locked_q <= (state_d == LOCKED);
    end
  end

`ifdef SEQ_STATS_EN
  logic [15:0] stats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= 16'd0;
    end else if (kill_d && (stats_q != 16'hFFFF)) begin
      stats_q <= stats_q + 16'd1;
    end
  end

  assign sync_err_count = stats_q;
`else
  assign sync_err_count = 16'd0;
`endif

  assign frame_counter = fc_q;
  assign in_channel    = in_ch_q;
  assign out_channel   = out_ch_q;
  assign kill          = kill_q;
  assign locked        = locked_q;
  assign block_start   = bs_q;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Sync and sequencing controller for frame_dismantle on the optical receive path. It consumes preamble-detect events from the line decoder and subframe-complete events from the dismantler. It tracks block position (frame 0..191) and channel (A/B), and drives frame_counter, in_channel and out_channel into the dismantler. It aborts the dismantler via kill on sync errors and runs a search/acquire/lock state machine.

Parameters:
FRAMES_PER_BLOCK, 192, frames per channel-status block; frame_counter wraps at this value.
LOCK_FRAMES, 4, consecutive matching preambles required to declare lock.
MISS_LIMIT, 3, consecutive mismatches in LOCKED before falling back to SEARCH.
TIMEOUT, 64, clk cycles without a pre_valid before the watchdog fires.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
pre_valid  in  1  one-cycle pulse: preamble detected
pre_type  in  2  0=B (block start, ch A), 1=M (ch A), 2=W (ch B), 3=invalid
done  in  1  one-cycle pulse from dismantler: subframe fully parsed
frame_counter  out  8  current frame index, 0..FRAMES_PER_BLOCK-1
in_channel  out  1  channel of subframe being parsed (0=A, 1=B)
out_channel  out  1  channel of last completed subframe
kill  out  1  one-cycle abort pulse to dismantler
locked  out  1  high in LOCKED state
block_start  out  1  one-cycle pulse on accepted B preamble while LOCKED
sync_err_count  out  16  saturating mismatch/timeout count

Behaviour:
- Reset (async, rst_n=0): state=SEARCH; all outputs 0; busy=0; good_cnt=0; err_cnt=0; watchdog=0. Release is synchronous to clk.
- Expected preamble is derived from the current registered pair (frame_counter, in_channel):
  - in_channel=1 → W
  - in_channel=0 and frame_counter=0 → B
  - otherwise → M
- A pre_valid is a mismatch if pre_type≠expected, pre_type=3, or busy=1 (no intervening done).
- An accepted pre_valid sets busy=1. done clears busy.
- On done: out_channel<=in_channel; in_channel toggles; when in_channel was 1, frame_counter increments and wraps FRAMES_PER_BLOCK-1→0.
- done with busy=0 is ignored; no counter change.
- pre_valid and done in the same cycle: done is applied first, then pre_valid is checked against the advanced expectation.
- SEARCH:
  - ignores done.
  - pre_valid with B → frame_counter=0, in_channel=0, busy=1, good_cnt=1, go to ACQUIRE.
  - other types are ignored.
  - no kill is issued from SEARCH.
- ACQUIRE:
  - match → good_cnt++; reaching LOCK_FRAMES → LOCKED, and locked rises the next cycle.
  - mismatch → kill, SEARCH.
- LOCKED:
  - match → err_cnt=0; a B match pulses block_start.
  - mismatch → kill, err_cnt++, resync to the observed preamble: B → frame 0/ch A; M → ch A, frame kept; W → ch B, frame kept; invalid → no resync, busy=0. For B/M/W, busy=1.
  - err_cnt reaching MISS_LIMIT → SEARCH, locked=0.
- Watchdog:
  - counts clk in ACQUIRE/LOCKED; cleared on any pre_valid.
  - reaching TIMEOUT-1 → kill, SEARCH, busy=0.
- kill, block_start and locked are registered: they assert the cycle after the causing event.
- kill is exactly 1 cycle. Back-to-back errors give back-to-back pulses.
- frame_counter, in_channel and out_channel are not altered by a transition to SEARCH; they change only on the next B.

Optional Feature:
SEQ_STATS_EN:
- Defined: sync_err_count increments on every kill, saturating at 16'hFFFF. It is cleared only by reset.
- Undefined: the port is present but tied to 0, and no counter logic is synthesised.

Decomposition:
- frame_pkg holds:
  - preamble_t enum (PRE_B, PRE_M, PRE_W, PRE_INV)
  - seq_state_t enum (SEARCH, ACQUIRE, LOCKED)
  - FRAMES_PER_BLOCK default constant
  - channel encoding constants CH_A/CH_B
- One sub-module, seq_watchdog: TIMEOUT-parameterised counter with clear/enable inputs and a one-cycle expire output.

Test Plan:
- Lock acquisition: reset, then B,W,M,W each followed by done → locked=1 one cycle after the 4th pre_valid; frame_counter=1 after the 2nd done.
- Block wrap: locked, run 192 frames → frame_counter 191→0 on the ch-B done; the next B pulses block_start. Sending M at frame 0 instead → kill, sync_err_count=1.
- Single-error tolerance in LOCKED: inject W where M is expected → 1-cycle kill, locked stays 1, in_channel=1. Three consecutive mismatches → locked=0, state SEARCH.
- Timeout: locked, no pre_valid for 64 cycles → kill on the 64th cycle, locked=0. A subsequent B re-enters ACQUIRE.
- Same-cycle events: pre_valid=W and done (ch A) in the same cycle → accepted as a match, no kill.
- Premature preamble: second pre_valid with no done → mismatch → kill.
- Reset mid-frame: rst_n low at frame 100 → all outputs 0 immediately, without waiting for a clk edge.
